mmu_tlb_ctrl: RTL and testbench

Translation controller for the four-entry MMU tag RAM. It accepts a virtual address and looks up the tag RAM through its read port. On a hit it returns the physical address. On a miss it performs a single-level page-table read over a request/acknowledge memory port, then writes the result into the tag RAM via WR_MRAM/MMU_DIN. It also flushes all four entries on command. It sits directly upstream (writer) and downstream (reader) of the tag RAM.

---
 rtl/mmu_tlb_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mmu_tlb_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tlb_ctrl.sv
// mmu_tlb_ctrl: translation controller for the four-entry MMU tag RAM.
// Looks up a virtual address in the tag RAM, walks a single-level page
// table over a request/acknowledge port on a miss, refills the tag RAM,
// and invalidates all four entries on a flush command.
// Every output is driven straight from a flop.
module mmu_tlb_ctrl (
    input  logic        BCLK,
    input  logic        BRESET,
    input  logic        REQ,
    input  logic        WRITE,
    input  logic [31:0] VADR,
    input  logic        FLUSH,
    input  logic [15:0] PTB,
    output logic [1:0]  TAG_RD,
    input  logic [35:0] TAG_DATA,
    output logic [31:0] VADR_W,
    output logic        WR_MRAM,
    output logic [23:0] MMU_DIN,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAULT,
    output logic [31:0] PADDR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WALK   = 3'd2,
        ST_FILL   = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] va_l_r, va_l_s;
    logic        wr_l_r, wr_l_s;
    logic [2:0]  cnt_r, cnt_s;

    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        fault_r, fault_s;
    logic [31:0] paddr_r, paddr_s;
    logic        mem_req_r, mem_req_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic        wr_mram_r, wr_mram_s;
    logic [23:0] mmu_din_r, mmu_din_s;
    logic [31:0] vadr_w_r, vadr_w_s;
    logic [1:0]  tag_rd_r, tag_rd_s;

    logic        hit_s;
    logic        perm_ok_s;
    logic        unused_s;

    // Write-side address for flush step cnt; the last step keeps index 3 so
    // the address stays put while the final write completes.
    function automatic logic [31:0] flush_addr(input logic [2:0] cnt);
        logic [1:0] idx;
        idx = (cnt > 3'd3) ? 2'd3 : cnt[1:0];
        return {12'h000, idx, 18'h00000};
    endfunction

    assign hit_s     = (TAG_DATA[35:24] == va_l_r[31:20]) && TAG_DATA[0];
    assign perm_ok_s = !wr_l_r || TAG_DATA[1];
    // PTE bits [17:2] and entry bits [9:2] carry nothing this block uses.
    assign unused_s  = ^{MEM_DATA[17:2], TAG_DATA[9:2]};

    // State register and registered outputs.
    always_ff @(posedge BCLK or negedge BRESET) begin
        if (!BRESET) begin
            state_r    <= ST_IDLE;
            va_l_r     <= 32'h0000_0000;
            wr_l_r     <= 1'b0;
            cnt_r      <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
            paddr_r    <= 32'h0000_0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            wr_mram_r  <= 1'b0;
            mmu_din_r  <= 24'h00_0000;
            vadr_w_r   <= 32'h0000_0000;
            tag_rd_r   <= 2'd0;
        end else begin
            state_r    <= state_s;
            va_l_r     <= va_l_s;
            wr_l_r     <= wr_l_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            fault_r    <= fault_s;
            paddr_r    <= paddr_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            wr_mram_r  <= wr_mram_s;
            mmu_din_r  <= mmu_din_s;
            vadr_w_r   <= vadr_w_s;
            tag_rd_r   <= tag_rd_s;
        end
    end

    // Next-state logic and next values for the output flops.
    always_comb begin
        state_s    = state_r;
        va_l_s     = va_l_r;
        wr_l_s     = wr_l_r;
        cnt_s      = cnt_r;
        fault_s    = fault_r;
        paddr_s    = paddr_r;
        mem_addr_s = mem_addr_r;
        mmu_din_s  = mmu_din_r;
        vadr_w_s   = vadr_w_r;
        tag_rd_s   = tag_rd_r;
        case (state_r)
            ST_IDLE: begin
                if (FLUSH) begin
                    // A simultaneous REQ is dropped on purpose.
                    state_s   = ST_FLUSH;
                    cnt_s     = 3'd0;
                    mmu_din_s = 24'h00_0000;
                    vadr_w_s  = flush_addr(3'd0);
                end else if (REQ) begin
                    state_s  = ST_LOOKUP;
                    va_l_s   = VADR;
                    wr_l_s   = WRITE;
                    vadr_w_s = VADR;
                    tag_rd_s = VADR[19:18];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    state_s = ST_RESP;
                    if (perm_ok_s) begin
                        fault_s = 1'b0;
                        paddr_s = {TAG_DATA[23:10], va_l_r[17:0]};
                    end else begin
                        fault_s = 1'b1;
                        paddr_s = 32'h0000_0000;
                    end
                end else begin
                    state_s    = ST_WALK;
                    mem_addr_s = {PTB, va_l_r[31:18], 2'b00};
                end
            end
            ST_WALK: begin
                if (MEM_ACK) begin
                    mem_addr_s = 32'h0000_0000;
                    if (MEM_DATA[0]) begin
                        state_s   = ST_FILL;
                        mmu_din_s = {MEM_DATA[31:18], 8'h00, MEM_DATA[1:0]};
                    end else begin
                        state_s = ST_RESP;
                        fault_s = 1'b1;
                        paddr_s = 32'h0000_0000;
                    end
                end else begin
                    state_s = ST_WALK;
                end
            end
            ST_FILL: begin
                // Re-lookup picks up the fresh entry and applies the W check.
                state_s = ST_LOOKUP;
            end
            ST_FLUSH: begin
                if (cnt_r == 3'd4) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s    = cnt_r + 3'd1;
                    vadr_w_s = flush_addr(cnt_r + 3'd1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s    = (state_s != ST_IDLE);
        done_s    = (state_s == ST_RESP);
        mem_req_s = (state_s == ST_WALK);
        // The tag RAM writes the address it registered one cycle earlier, so
        // the flush write strobe trails the index by one cycle.
        wr_mram_s = (state_s == ST_FILL) || ((state_s == ST_FLUSH) && (cnt_s != 3'd0));
    end

    assign TAG_RD   = tag_rd_r;
    assign VADR_W   = vadr_w_r;
    assign WR_MRAM  = wr_mram_r;
    assign MMU_DIN  = mmu_din_r;
    assign MEM_REQ  = mem_req_r;
    assign MEM_ADDR = mem_addr_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign FAULT    = fault_r;
    assign PADDR    = paddr_r;

endmodule

// File: tb/tb_mmu_tlb_ctrl.sv
// Self-checking bench for mmu_tlb_ctrl with a behavioural four-entry tag RAM
// (address registered on the rising edge, written on the falling edge).
module tb_mmu_tlb_ctrl;

    logic        BCLK = 1'b0;
    logic        BRESET;
    logic        REQ;
    logic        WRITE;
    logic [31:0] VADR;
    logic        FLUSH;
    logic [15:0] PTB;
    logic [1:0]  TAG_RD;
    logic [35:0] TAG_DATA;
    logic [31:0] VADR_W;
    logic        WR_MRAM;
    logic [23:0] MMU_DIN;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_DATA;
    logic        BUSY;
    logic        DONE;
    logic        FAULT;
    logic [31:0] PADDR;

    int checks;
    int errors;

    logic [35:0] ram [4];
    logic [31:0] vadr_w_q;
    logic        preload;
    int          wr_cnt;
    int          done_cnt;
    logic [7:0]  wr_idx_log;
    logic [23:0] last_din;
    logic [1:0]  last_idx;

    mmu_tlb_ctrl dut (
        .BCLK(BCLK), .BRESET(BRESET), .REQ(REQ), .WRITE(WRITE), .VADR(VADR),
        .FLUSH(FLUSH), .PTB(PTB), .TAG_RD(TAG_RD), .TAG_DATA(TAG_DATA),
        .VADR_W(VADR_W), .WR_MRAM(WR_MRAM), .MMU_DIN(MMU_DIN), .MEM_REQ(MEM_REQ),
        .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .BUSY(BUSY),
        .DONE(DONE), .FAULT(FAULT), .PADDR(PADDR)
    );

    always #5 BCLK = ~BCLK;

    assign TAG_DATA = ram[TAG_RD];

    // Tag RAM write-address register.
    always @(posedge BCLK or negedge BRESET) begin
        if (!BRESET) vadr_w_q <= 32'h0;
        else         vadr_w_q <= VADR_W;
    end

    // Tag RAM write port plus write/done bookkeeping.
    always @(negedge BCLK) begin
        if (preload) begin
            // Stale valid entries whose tags match later requests.
            ram[0]     <= {12'h00C, 14'h0111, 8'h00, 2'b11};
            ram[1]     <= {12'h003, 14'h0AAA, 8'h00, 2'b11};
            ram[2]     <= {12'h123, 14'h0222, 8'h00, 2'b11};
            ram[3]     <= {12'h00C, 14'h0333, 8'h00, 2'b11};
            wr_cnt     <= 0;
            done_cnt   <= 0;
            wr_idx_log <= 8'h00;
            last_din   <= 24'h0;
            last_idx   <= 2'd0;
        end else begin
            if (WR_MRAM) begin
                ram[vadr_w_q[19:18]] <= {vadr_w_q[31:20], MMU_DIN};
                wr_cnt     <= wr_cnt + 1;
                wr_idx_log <= {wr_idx_log[5:0], vadr_w_q[19:18]};
                last_din   <= MMU_DIN;
                last_idx   <= vadr_w_q[19:18];
            end
            if (DONE) done_cnt <= done_cnt + 1;
        end
    end

    // Issue one request and act as the page-table memory. lat is the number of
    // cycles from the REQ sampling edge to the cycle showing DONE (-1 = none).
    task automatic do_req(input logic [31:0] va, input logic wr, input int ack_dly,
                          input logic [31:0] pte, output int lat, output logic [31:0] pa,
                          output logic flt, output int mreq_n, output logic [31:0] maddr,
                          output logic stable);
        lat = -1; pa = 32'hX; flt = 1'bX; mreq_n = 0; maddr = 32'h0; stable = 1'b1;
        @(posedge BCLK); #1;
        REQ = 1'b1; VADR = va; WRITE = wr;
        @(posedge BCLK); #1;
        REQ = 1'b0; VADR = 32'h5A5A_5A5A;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge BCLK);
            MEM_ACK = 1'b0; MEM_DATA = 32'hDEAD_BEEF;
            if (MEM_REQ) begin
                mreq_n++;
                if (mreq_n == 1) maddr = MEM_ADDR;
                else if (MEM_ADDR !== maddr) stable = 1'b0;
                if (mreq_n == ack_dly + 1) begin
                    MEM_ACK = 1'b1; MEM_DATA = pte;
                end
            end
            if (DONE) begin
                lat = c; pa = PADDR; flt = FAULT;
            end
        end
        MEM_ACK = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        BRESET = 1'b0; preload = 1'b1;
        repeat (3) @(posedge BCLK);
        @(negedge BCLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", DONE); end
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, expected 0", FAULT); end
        checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h, expected 0", PADDR); end
        checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, expected 0", MEM_REQ); end
        checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", MEM_ADDR); end
        checks++; if (WR_MRAM !== 1'b0) begin errors++; $display("FAIL reset_wr_mram: got %b, expected 0", WR_MRAM); end
        checks++; if (MMU_DIN !== 24'h0) begin errors++; $display("FAIL reset_mmu_din: got %h, expected 0", MMU_DIN); end
        checks++; if (VADR_W !== 32'h0) begin errors++; $display("FAIL reset_vadr_w: got %h, expected 0", VADR_W); end
        checks++; if (TAG_RD !== 2'd0) begin errors++; $display("FAIL reset_tag_rd: got %h, expected 0", TAG_RD); end
        @(posedge BCLK); #1;
        preload = 1'b0; BRESET = 1'b1;
    endtask

    task automatic test_flush_with_req();
        int w0, d0, busy_n;
        logic [31:0] vw [5];
        logic [31:0] exp_vw;
        w0 = wr_cnt; d0 = done_cnt; busy_n = 0;
        for (int k = 0; k < 5; k++) vw[k] = 32'hFFFF_FFFF;
        @(posedge BCLK); #1;
        FLUSH = 1'b1; REQ = 1'b1; VADR = 32'h0034_5678; WRITE = 1'b0;
        @(posedge BCLK); #1;
        FLUSH = 1'b0; REQ = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge BCLK);
            if (BUSY) begin
                if (busy_n < 5) vw[busy_n] = VADR_W;
                busy_n++;
            end
        end
        #1;
        checks++; if (busy_n !== 5) begin errors++; $display("FAIL flush_busy_cycles: got %0d, expected 5", busy_n); end
        checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL flush_wr_pulses: got %0d, expected 4", wr_cnt - w0); end
        checks++; if (wr_idx_log !== 8'h1B) begin errors++; $display("FAIL flush_index_order: got %h, expected 1b", wr_idx_log); end
        checks++; if (last_din !== 24'h0) begin errors++; $display("FAIL flush_din: got %h, expected 0", last_din); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL flush_no_done: got %0d, expected 0", done_cnt - d0); end
        for (int k = 0; k < 4; k++) begin
            exp_vw = 32'h0 | (k << 18);
            checks++; if (vw[k] !== exp_vw) begin errors++; $display("FAIL flush_vadr_w%0d: got %h, expected %h", k, vw[k], exp_vw); end
        end
        checks++; if (BUSY !== 1'b0 || MEM_REQ !== 1'b0) begin errors++; $display("FAIL flush_req_dropped: got busy %b mem_req %b, expected 0 0", BUSY, MEM_REQ); end
    endtask

    task automatic test_miss_fill();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st;
        w0 = wr_cnt;
        do_req(32'h0034_5678, 1'b0, 0, 32'h0008_0003, lat, pa, flt, mn, ma, st);
        checks++; if (mn !== 1) begin errors++; $display("FAIL miss_mem_req_cycles: got %0d, expected 1", mn); end
        checks++; if (ma !== 32'h0010_0034) begin errors++; $display("FAIL miss_mem_addr: got %h, expected 00100034", ma); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL miss_wr_pulses: got %0d, expected 1", wr_cnt - w0); end
        checks++; if (last_din !== 24'h000803) begin errors++; $display("FAIL miss_mmu_din: got %h, expected 000803", last_din); end
        checks++; if (last_idx !== 2'd1) begin errors++; $display("FAIL miss_fill_index: got %0d, expected 1", last_idx); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL miss_latency: got %0d, expected 5", lat); end
        checks++; if (pa !== 32'h0008_5678) begin errors++; $display("FAIL miss_paddr: got %h, expected 00085678", pa); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL miss_fault: got %b, expected 0", flt); end
    endtask

    task automatic test_hit_repeat();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st;
        w0 = wr_cnt;
        do_req(32'h0034_5678, 1'b0, 0, 32'h0000_0000, lat, pa, flt, mn, ma, st);
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d, expected 2", lat); end
        checks++; if (mn !== 0) begin errors++; $display("FAIL hit_mem_req: got %0d cycles, expected 0", mn); end
        checks++; if (pa !== 32'h0008_5678) begin errors++; $display("FAIL hit_paddr: got %h, expected 00085678", pa); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL hit_fault: got %b, expected 0", flt); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL hit_no_write: got %0d, expected 0", wr_cnt - w0); end
    endtask

    task automatic test_write_protect();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st;
        w0 = wr_cnt;
        do_req(32'h1238_0ABC, 1'b1, 0, 32'h0008_0001, lat, pa, flt, mn, ma, st);
        checks++; if (ma !== 32'h0010_1238) begin errors++; $display("FAIL wp_mem_addr: got %h, expected 00101238", ma); end
        checks++; if (last_din !== 24'h000801 || wr_cnt - w0 !== 1) begin errors++; $display("FAIL wp_fill: got din %h writes %0d, expected 000801 1", last_din, wr_cnt - w0); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL wp_latency: got %0d, expected 5", lat); end
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL wp_fault: got %b, expected 1", flt); end
        checks++; if (pa !== 32'h0) begin errors++; $display("FAIL wp_paddr: got %h, expected 0", pa); end
        do_req(32'h1238_0ABC, 1'b0, 0, 32'h0000_0000, lat, pa, flt, mn, ma, st);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wp_read_latency: got %0d, expected 2", lat); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL wp_read_fault: got %b, expected 0", flt); end
        checks++; if (pa !== 32'h0008_0ABC) begin errors++; $display("FAIL wp_read_paddr: got %h, expected 00080abc", pa); end
    endtask

    task automatic test_invalid_pte();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st;
        w0 = wr_cnt;
        do_req(32'h00C0_1000, 1'b0, 0, 32'h0004_0000, lat, pa, flt, mn, ma, st);
        checks++; if (ma !== 32'h0010_00C0) begin errors++; $display("FAIL inv_mem_addr: got %h, expected 001000c0", ma); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL inv_latency: got %0d, expected 3", lat); end
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL inv_fault: got %b, expected 1", flt); end
        checks++; if (pa !== 32'h0) begin errors++; $display("FAIL inv_paddr: got %h, expected 0", pa); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL inv_no_write: got %0d, expected 0", wr_cnt - w0); end
    endtask

    task automatic test_slow_ack();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st;
        w0 = wr_cnt;
        do_req(32'h00CC_0123, 1'b0, 7, 32'h00FC_0007, lat, pa, flt, mn, ma, st);
        checks++; if (mn !== 8) begin errors++; $display("FAIL slow_mem_req_cycles: got %0d, expected 8", mn); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL slow_addr_stable: got %b, expected 1", st); end
        checks++; if (ma !== 32'h0010_00CC) begin errors++; $display("FAIL slow_mem_addr: got %h, expected 001000cc", ma); end
        checks++; if (last_din !== 24'h00FC03 || last_idx !== 2'd3) begin errors++; $display("FAIL slow_fill: got din %h idx %0d, expected 00fc03 3", last_din, last_idx); end
        checks++; if (lat !== 12) begin errors++; $display("FAIL slow_latency: got %0d, expected 12", lat); end
        checks++; if (pa !== 32'h00FC_0123 || flt !== 1'b0) begin errors++; $display("FAIL slow_paddr: got %h fault %b, expected 00fc0123 0", pa, flt); end
    endtask

    task automatic test_reset_walk();
        int w0, lat, mn; logic [31:0] pa, ma; logic flt, st, seen;
        w0 = wr_cnt; seen = 1'b0;
        @(posedge BCLK); #1;
        REQ = 1'b1; VADR = 32'h0200_0000; WRITE = 1'b0;
        @(posedge BCLK); #1;
        REQ = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge BCLK);
            if (MEM_REQ) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_walk_entry: got %b, expected 1", seen); end
        #2; BRESET = 1'b0; #1;
        checks++; if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rst_walk_async: got mem_req %b busy %b, expected 0 0", MEM_REQ, BUSY); end
        checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL rst_walk_addr: got %h, expected 0", MEM_ADDR); end
        @(negedge BCLK); BRESET = 1'b1;
        repeat (2) @(posedge BCLK);
        #1;
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rst_walk_no_write: got %0d, expected 0", wr_cnt - w0); end
        do_req(32'h0200_0000, 1'b0, 0, 32'h0100_0003, lat, pa, flt, mn, ma, st);
        checks++; if (ma !== 32'h0010_0200 || mn !== 1) begin errors++; $display("FAIL rst_next_walk: got addr %h cycles %0d, expected 00100200 1", ma, mn); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rst_next_latency: got %0d, expected 5", lat); end
        checks++; if (pa !== 32'h0100_0000 || flt !== 1'b0) begin errors++; $display("FAIL rst_next_paddr: got %h fault %b, expected 01000000 0", pa, flt); end
    endtask

    initial begin
        checks = 0; errors = 0;
        BRESET = 1'b0; preload = 1'b1;
        REQ = 1'b0; WRITE = 1'b0; VADR = 32'h0; FLUSH = 1'b0;
        PTB = 16'h0010; MEM_ACK = 1'b0; MEM_DATA = 32'hDEAD_BEEF;
        test_reset();
        test_flush_with_req();
        test_miss_fill();
        test_hit_repeat();
        test_write_protect();
        test_invalid_pte();
        test_slow_ack();
        test_reset_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
